// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per step over a
// req/ready/rvalid handshake, and forms the next PC when the datapath commits.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        commit,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic [1:0]  jump,
   input  logic [31:0] jr_target,
   output logic        misaligned,
   output logic [31:0] instret
);

   localparam int unsigned XLEN     = 32;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned JIDX_W   = 26;
   localparam int unsigned BR_EXT_W = XLEN - IMM_W - 2;

   localparam logic [1:0] JMP_J  = 2'b01;
   localparam logic [1:0] JMP_JR = 2'b10;

   typedef enum logic [1:0] {
      S_REQ  = 2'b00,
      S_WAIT = 2'b01,
      S_HOLD = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   ir_q, ir_d;
   logic [XLEN-1:0]   instret_q, instret_d;
   logic              ir_valid_q, ir_valid_d;
   logic              misaligned_q, misaligned_d;

   logic [XLEN-1:0]   pc_plus4_c;
   logic [XLEN-1:0]   br_offset_c;
   logic [XLEN-1:0]   br_target_c;
   logic [XLEN-1:0]   j_target_c;
   logic [XLEN-1:0]   jr_aligned_c;
   logic [XLEN-1:0]   next_pc_c;
   logic              jr_misaligned_c;

   // Candidate targets; only consulted in the commit cycle.
   always_comb begin
      pc_plus4_c      = pc_q + XLEN'(4);
      br_offset_c     = {{BR_EXT_W{ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0], 2'b00};
      br_target_c     = pc_plus4_c + br_offset_c;
      j_target_c      = {pc_plus4_c[XLEN-1:XLEN-4], ir_q[JIDX_W-1:0], 2'b00};
      jr_aligned_c    = {jr_target[XLEN-1:2], 2'b00};
      jr_misaligned_c = (jump == JMP_JR) && (jr_target[1:0] != 2'b00);
   end

   // jr beats j beats taken branch beats fall-through; jump=11 falls through.
   always_comb begin
      next_pc_c = pc_plus4_c;
      if (jump == JMP_JR) begin
         next_pc_c = jr_aligned_c;
      end else if (jump == JMP_J) begin
         next_pc_c = j_target_c;
      end else if (branch && branch_taken) begin
         next_pc_c = br_target_c;
      end
   end

   // Next-state and datapath update for the fetch handshake.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      instret_d    = instret_q;
      ir_valid_d   = ir_valid_q;
      misaligned_d = misaligned_q;

      unique case (state_q)
         S_REQ: begin
            if (imem_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (commit) begin
               pc_d         = next_pc_c;
               instret_d    = instret_q + XLEN'(1);
               ir_valid_d   = 1'b0;
               misaligned_d = misaligned_q | jr_misaligned_c;
               state_d      = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         instret_q    <= '0;
         ir_valid_q   <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         instret_q    <= instret_d;
         ir_valid_q   <= ir_valid_d;
         misaligned_q <= misaligned_d;
      end
   end

   // Request is a pure decode of the state register, so no input reaches it.
   assign imem_req   = (state_q == S_REQ);
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign pc_plus4   = pc_plus4_c;
   assign ir         = ir_q;
   assign ir_valid   = ir_valid_q;
   assign misaligned = misaligned_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: the bench plays instruction memory
// and datapath, and a transaction-level model predicts every visible output.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0040;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        commit;
   logic        branch;
   logic        branch_taken;
   logic [1:0]  jump;
   logic [31:0] jr_target;
   logic        misaligned;
   logic [31:0] instret;

   instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ir(ir), .ir_valid(ir_valid), .pc(pc), .pc_plus4(pc_plus4),
      .commit(commit), .branch(branch), .branch_taken(branch_taken),
      .jump(jump), .jr_target(jr_target),
      .misaligned(misaligned), .instret(instret)
   );

   // Model of the architecturally visible state.
   logic [31:0] m_pc, m_ir, m_ins;
   logic        m_irv, m_mis, m_req;
   bit          chk_en;
   int          checks;
   int          errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                              input logic br, input logic bt,
                                              input logic [1:0] j, input logic [31:0] t);
      logic [31:0] p4;
      int          off;
      p4 = p + 32'd4;
      if (j == 2'b10) return t & 32'hFFFF_FFFC;
      if (j == 2'b01) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if (br && bt) begin
         off = int'($signed(w[15:0]));
         return p4 + 32'(off * 4);
      end
      return p4;
   endfunction

   task automatic model_reset();
      m_pc  = RST_PC;
      m_ir  = 32'h0;
      m_ins = 32'h0;
      m_irv = 1'b0;
      m_mis = 1'b0;
      m_req = 1'b1;
   endtask

   // Every cycle, away from the active edge, all outputs must match the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", 32'(imem_req), 32'(m_req));
         if (m_req) chk("imem_addr", imem_addr, m_pc);
         chk("pc", pc, m_pc);
         chk("pc_plus4", pc_plus4, m_pc + 32'd4);
         chk("ir_valid", 32'(ir_valid), 32'(m_irv));
         chk("ir", ir, m_ir);
         chk("instret", instret, m_ins);
         chk("misaligned", 32'(misaligned), 32'(m_mis));
      end
   end

   task automatic rnd_ctrl();
      branch       = 1'($urandom);
      branch_taken = 1'($urandom);
      jump         = 2'($urandom);
      jr_target    = $urandom;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full fetch/execute transaction; noise drives ignored inputs.
   task automatic do_instr(input logic [31:0] w, input int stall, input int lat, input int hold,
                           input logic br, input logic bt, input logic [1:0] jmp,
                           input logic [31:0] jrt, input bit noise);
      logic [31:0] nxt;
      logic        nmis;
      for (int i = 0; i < stall; i++) begin
         imem_ready  = 1'b0;
         commit      = noise;
         imem_rvalid = noise;
         imem_rdata  = $urandom;
         rnd_ctrl();
         step();
      end
      commit      = 1'b0;
      imem_rvalid = 1'b0;
      imem_ready  = 1'b1;
      step();
      imem_ready = 1'b0;
      m_req      = 1'b0;
      for (int i = 0; i < lat; i++) begin
         commit = noise;
         rnd_ctrl();
         step();
      end
      commit      = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = w;
      step();
      imem_rvalid = 1'b0;
      m_ir        = w;
      m_irv       = 1'b1;
      for (int i = 0; i < hold; i++) begin
         imem_rvalid = noise;
         imem_rdata  = $urandom;
         rnd_ctrl();
         step();
      end
      imem_rvalid  = 1'b0;
      commit       = 1'b1;
      branch       = br;
      branch_taken = bt;
      jump         = jmp;
      jr_target    = jrt;
      nxt  = model_next(m_pc, m_ir, br, bt, jmp, jrt);
      nmis = m_mis | ((jmp == 2'b10) && (jrt[1:0] != 2'b00));
      step();
      commit = 1'b0;
      m_pc   = nxt;
      m_mis  = nmis;
      m_ins  = m_ins + 32'd1;
      m_irv  = 1'b0;
      m_req  = 1'b1;
   endtask

   task automatic jr_to(input logic [31:0] tgt);
      do_instr($urandom, 0, 0, 0, 1'b0, 1'b0, 2'b10, tgt, 1'b0);
   endtask

   // Abandon a fetch with reset while in WAIT, then send a stale rvalid.
   task automatic reset_in_wait(input bit literal);
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      m_req      = 1'b0;
      step();
      rst_n = 1'b0;
      model_reset();
      step();
      step();
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      step();
      imem_rvalid = 1'b0;
      if (literal) begin
         chk("rst_wait_ir_valid", 32'(ir_valid), 32'h0);
         chk("rst_wait_addr", imem_addr, 32'h0000_0040);
         chk("rst_wait_req", 32'(imem_req), 32'h1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      rst_n = 1'b0;
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
      commit = 1'b0;
      branch = 1'b0;
      branch_taken = 1'b0;
      jump = 2'b00;
      jr_target = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk("reset_addr", imem_addr, 32'h0000_0040);
      chk("reset_req", 32'(imem_req), 32'h1);
      chk("reset_pc_plus4", pc_plus4, 32'h0000_0044);
      chk("reset_ir", ir, 32'h0);

      do_instr(32'h0C00_0010, 0, 0, 1, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
      chk("first_ir_kept", ir, 32'h0C00_0010);
      chk("seq_addr", imem_addr, 32'h0000_0044);
      chk("seq_instret", instret, 32'h1);

      do_instr($urandom, 5, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
      chk("stall_pc", pc, 32'h0000_0048);

      jr_to(32'h0000_0100);
      do_instr(32'h1000_FFFE, 0, 1, 0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
      chk("br_taken_pc", pc, 32'h0000_00FC);
      jr_to(32'h0000_0100);
      do_instr(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      chk("br_not_taken_pc", pc, 32'h0000_0104);

      jr_to(32'h1000_0000);
      do_instr(32'h0800_0040, 0, 0, 0, 1'b0, 1'b0, 2'b01, 32'h0, 1'b0);
      chk("j_pc", pc, 32'h1000_0100);
      chk("j_not_misaligned", 32'(misaligned), 32'h0);
      do_instr($urandom, 0, 0, 0, 1'b1, 1'b1, 2'b10, 32'h0000_2003, 1'b0);
      chk("jr_pc", pc, 32'h0000_2000);
      chk("jr_misaligned", 32'(misaligned), 32'h1);

      jr_to(32'hFFFF_FFFC);
      chk("sticky_misaligned", 32'(misaligned), 32'h1);
      do_instr($urandom, 0, 3, 2, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
      chk("wrap_pc", pc, 32'h0000_0000);

      reset_in_wait(1'b1);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 24) == 0) reset_in_wait(1'b0);
         do_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 2'($urandom),
                  $urandom, 1'($urandom));
      end

      step();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the MIPS32 processor. Holds the program counter, fetches one instruction word per step from instruction memory over a request/response handshake, and presents it as `ir` to the control unit and datapath. Consumes the control unit's `branch` and `jump` decisions, plus the datapath's branch condition and `jr` register value, to form the next PC when the downstream datapath commits the current instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ready`  in  1  memory accepts the request this cycle when `imem_req & imem_ready`.
- `imem_rvalid`  in  1  read data valid, one or more cycles after acceptance.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  current instruction; stable while `ir_valid`=1.
- `ir_valid`  out  1  `ir` holds a fetched, uncommitted instruction.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational; the `jal` link value.
- `commit`  in  1  datapath has finished executing `ir`; sampled only while `ir_valid`=1.
- `branch`  in  1  from the control unit.
- `branch_taken`  in  1  branch condition result from the ALU.
- `jump`  in  2  from the control unit: 00 sequential, 01 `j`/`jal`, 10 `jr`, 11 treated as 00.
- `jr_target`  in  32  rs register value for `jr`.
- `misaligned`  out  1  sticky flag: a `jr` target had nonzero bits [1:0].
- `instret`  out  32  count of committed instructions.

## Operation
- FSM states:
  - REQ: `imem_req`=1. Moves to WAIT on `imem_ready`.
  - WAIT: `imem_req`=0. On `imem_rvalid`, captures `ir`←`imem_rdata`, sets `ir_valid`, and moves to HOLD.
  - HOLD: `ir_valid`=1. On `commit`, updates `pc`←next_pc, increments `instret`, clears `ir_valid`, and moves to REQ.
- next_pc priority, evaluated in the commit cycle:
  1. `jump`=10: `{jr_target[31:2],2'b00}`. Also sets `misaligned` if `jr_target[1:0]`≠0.
  2. `jump`=01: `{pc_plus4[31:28], ir[25:0], 2'b00}`.
  3. `branch & branch_taken`: `pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00}`, mod 2^32.
  4. Otherwise: `pc_plus4`.
- All PC arithmetic is 32-bit with silent wrap. PC 32'hFFFF_FFFC plus 4 gives 0.
- `instret` wraps from 32'hFFFF_FFFF to 0.
- `commit` outside HOLD is ignored. `imem_rvalid` outside WAIT is ignored.
- `ir` keeps its last value after `ir_valid` drops. It is overwritten only on capture.
- `misaligned` is cleared only by reset.

## Timing
- Reset values (asynchronous on `rst_n`=0): state REQ, `pc`=`RESET_PC`, `ir`=0, `ir_valid`=0, `misaligned`=0, `instret`=0. `imem_req` is 1 from the first edge after reset release, and in fact combinationally in REQ.
- Reset asserted mid-fetch abandons the transaction. A late `imem_rvalid` arriving in REQ is ignored, so memory must not return data for an abandoned request after reset.
- Best case with `imem_ready`=1 and rvalid one cycle after acceptance:
  - commit at edge N gives REQ in cycle N+1 and acceptance at edge N+1.
  - WAIT in cycle N+2, with rvalid sampled at edge N+2.
  - `ir_valid`=1 in cycle N+3.
  - Throughput is one instruction per 3 cycles plus memory and execute latency.
- `imem_addr` and `imem_req` are registered-state outputs with no combinational path from any input.
- `pc_plus4` and `imem_addr` track `pc` in the same cycle.
- `commit` and `imem_rvalid` cannot be simultaneous in a meaningful way, because they are legal in disjoint states.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040 and `imem_ready`=1, rvalid=1 in the following cycle, data 32'h0C00_0010 -> `imem_addr`=0x40, then `ir`=0x0C00_0010 with `ir_valid`=1 two cycles after release. `pc_plus4`=0x44.
- Sequential: commit with `jump`=00, `branch`=0 -> next `imem_addr`=0x44 and `instret`=1. Hold `imem_ready`=0 for 5 cycles -> `imem_req` stays 1 and the address is stable.
- Branch at pc=0x100 with `ir[15:0]`=16'hFFFE:
  - `branch`=1, `branch_taken`=1 -> next pc=0xFC.
  - `branch_taken`=0 -> next pc=0x104.
- Jump at pc=0x1000_0000 with `ir[25:0]`=26'h000_0040, `jump`=01 -> next pc=0x1000_0100. With `jump`=10 and `branch`=1, `branch_taken`=1, `jr_target`=0x0000_2003 -> next pc=0x2000 and `misaligned`=1 (sticky).
- Wrap: pc=0xFFFF_FFFC, sequential commit -> pc=0. Commit pulsed in WAIT -> ignored, and `instret` does not change.
- Reset asserted in WAIT, then rvalid pulsed right after release -> `ir_valid` stays 0, and `imem_addr`=`RESET_PC` with `imem_req`=1.
